// File: rtl/fsqrt_wrap.sv
// IEEE-754 single-precision square root wrapper around an external 24-bit sqrt core.
// Build option: define FSQRT_SUBNORM_EN to normalize subnormal operands instead of flushing them to zero.
module fsqrt_wrap (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] rs1,
    input  logic [2:0]  rm,
    output logic        busy,
    output logic        sqrt_start,
    output logic        sqrt_is_exp_odd,
    output logic [23:0] sqrt_significand,
    input  logic        sqrt_done,
    input  logic [43:0] sqrt_root,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  fflags
);

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_WAIT, S_ROUND, S_OUT} state_t;

    state_t      state_q, state_d;
    logic [31:0] rs1_q, rs1_d;
    logic [2:0]  rm_q, rm_d;
    logic        busy_q, busy_d;
    logic        sqrt_start_q, sqrt_start_d;
    logic        exp_odd_q, exp_odd_d;
    logic [23:0] sig_q, sig_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  fflags_q, fflags_d;
    logic        special_q, special_d;
    logic [31:0] spec_res_q, spec_res_d;
    logic        spec_nv_q, spec_nv_d;
    logic [7:0]  res_exp_q, res_exp_d;
    logic [43:0] root_q, root_d;

    // Operand decode of the captured rs1
    logic        op_sign;
    logic [7:0]  op_exp;
    logic [22:0] op_frac;
    logic        is_nan, is_inf, is_zero, is_sub, rm_bad, sub_as_zero;
    logic signed [9:0] unb_exp;
    logic signed [9:0] half_exp;
    logic [23:0] norm_sig;

    assign op_sign = rs1_q[31];
    assign op_exp  = rs1_q[30:23];
    assign op_frac = rs1_q[22:0];
    assign is_nan  = (op_exp == 8'hFF) && (op_frac != 23'd0);
    assign is_inf  = (op_exp == 8'hFF) && (op_frac == 23'd0);
    assign is_zero = (op_exp == 8'h00) && (op_frac == 23'd0);
    assign is_sub  = (op_exp == 8'h00) && (op_frac != 23'd0);
    assign rm_bad  = (rm_q > 3'd4);

`ifdef FSQRT_SUBNORM_EN
    logic [4:0] lz;

    // Leading zeros of {0,frac}; the highest set bit wins because it is assigned last.
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (i < 23 && op_frac[i]) begin
                lz = 5'(23 - i);
            end
        end
    end

    always_comb begin
        if (is_sub) begin
            norm_sig = {1'b0, op_frac} << lz;
            unb_exp  = -10'sd126 - $signed({5'b00000, lz});
        end else begin
            norm_sig = {1'b1, op_frac};
            unb_exp  = $signed({2'b00, op_exp}) - 10'sd127;
        end
    end

    assign sub_as_zero = 1'b0;
`else
    assign norm_sig    = {1'b1, op_frac};
    assign unb_exp     = $signed({2'b00, op_exp}) - 10'sd127;
    assign sub_as_zero = is_sub;
`endif

    assign half_exp = (unb_exp >>> 1) + 10'sd127;

    logic        uk_special;
    logic [31:0] uk_res;
    logic        uk_nv;

    always_comb begin
        uk_special = 1'b1;
        uk_res     = QNAN;
        uk_nv      = 1'b0;
        if (rm_bad) begin
            uk_nv = 1'b1;
        end else if (is_nan) begin
            uk_nv = ~op_frac[22];
        end else if (is_zero || sub_as_zero) begin
            uk_res = {op_sign, 31'd0};
        end else if (op_sign) begin
            uk_nv = 1'b1;
        end else if (is_inf) begin
            uk_res = POS_INF;
        end else begin
            uk_special = 1'b0;
        end
    end

    // Rounding of the captured root: 24 significand bits, guard, sticky
    logic [23:0] rnd_sig;
    logic        guard, sticky, round_up;
    logic [24:0] rnd_sum;
    logic [7:0]  rnd_exp;
    logic [22:0] rnd_frac;

    assign rnd_sig = root_q[43:20];
    assign guard   = root_q[19];
    assign sticky  = |root_q[18:0];

    always_comb begin
        unique case (rm_q)
            3'b000:  round_up = guard & (sticky | rnd_sig[0]);
            3'b011:  round_up = guard | sticky;
            3'b100:  round_up = guard;
            default: round_up = 1'b0;
        endcase
    end

    assign rnd_sum  = {1'b0, rnd_sig} + {24'd0, round_up};
    assign rnd_exp  = res_exp_q + {7'd0, rnd_sum[24]};
    assign rnd_frac = rnd_sum[24] ? 23'd0 : rnd_sum[22:0];

    always_comb begin
        state_d      = state_q;
        rs1_d        = rs1_q;
        rm_d         = rm_q;
        sqrt_start_d = 1'b0;
        exp_odd_d    = exp_odd_q;
        sig_d        = sig_q;
        result_d     = result_q;
        fflags_d     = fflags_q;
        special_d    = special_q;
        spec_res_d   = spec_res_q;
        spec_nv_d    = spec_nv_q;
        res_exp_d    = res_exp_q;
        root_d       = root_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rs1_d   = rs1;
                    rm_d    = rm;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                special_d  = uk_special;
                spec_res_d = uk_res;
                spec_nv_d  = uk_nv;
                if (uk_special) begin
                    state_d = S_ROUND;
                end else begin
                    sig_d        = norm_sig;
                    exp_odd_d    = unb_exp[0];
                    res_exp_d    = half_exp[7:0];
                    sqrt_start_d = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sqrt_done) begin
                    root_d  = sqrt_root;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (special_q) begin
                    result_d = spec_res_q;
                    fflags_d = {spec_nv_q, 4'b0000};
                end else begin
                    result_d = {1'b0, rnd_exp, rnd_frac};
                    fflags_d = {4'b0000, guard | sticky};
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d != S_IDLE);
        out_valid_d = (state_d == S_OUT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rs1_q        <= 32'd0;
            rm_q         <= 3'd0;
            busy_q       <= 1'b0;
            sqrt_start_q <= 1'b0;
            exp_odd_q    <= 1'b0;
            sig_q        <= 24'd0;
            out_valid_q  <= 1'b0;
            result_q     <= 32'd0;
            fflags_q     <= 5'd0;
            special_q    <= 1'b0;
            spec_res_q   <= 32'd0;
            spec_nv_q    <= 1'b0;
            res_exp_q    <= 8'd0;
            root_q       <= 44'd0;
        end else begin
            state_q      <= state_d;
            rs1_q        <= rs1_d;
            rm_q         <= rm_d;
            busy_q       <= busy_d;
            sqrt_start_q <= sqrt_start_d;
            exp_odd_q    <= exp_odd_d;
            sig_q        <= sig_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            fflags_q     <= fflags_d;
            special_q    <= special_d;
            spec_res_q   <= spec_res_d;
            spec_nv_q    <= spec_nv_d;
            res_exp_q    <= res_exp_d;
            root_q       <= root_d;
        end
    end

    assign busy             = busy_q;
    assign sqrt_start       = sqrt_start_q;
    assign sqrt_is_exp_odd  = exp_odd_q;
    assign sqrt_significand = sig_q;
    assign out_valid        = out_valid_q;
    assign result           = result_q;
    assign fflags           = fflags_q;

endmodule

// File: tb/tb_fsqrt_wrap.sv
// Directed bench for fsqrt_wrap with a behavioural 4-cycle sqrt core model.
// Expected results are hand-computed constants; FSQRT_SUBNORM_EN selects the subnormal expectation.
module tb_fsqrt_wrap;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] rs1;
    logic [2:0]  rm;
    logic        busy;
    logic        sqrt_start;
    logic        sqrt_is_exp_odd;
    logic [23:0] sqrt_significand;
    logic        sqrt_done;
    logic [43:0] sqrt_root;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  fflags;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fsqrt_wrap dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .rs1              (rs1),
        .rm               (rm),
        .busy             (busy),
        .sqrt_start       (sqrt_start),
        .sqrt_is_exp_odd  (sqrt_is_exp_odd),
        .sqrt_significand (sqrt_significand),
        .sqrt_done        (sqrt_done),
        .sqrt_root        (sqrt_root),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result           (result),
        .fflags           (fflags)
    );

    // Sqrt core model: root = floor(sqrt(sig * 2^(63+odd))), leading one at bit 43
    logic        core_done;
    logic [43:0] core_root;
    logic [2:0]  core_cnt;
    logic        stray_done;

    assign sqrt_done = core_done | stray_done;
    assign sqrt_root = core_root;

    function automatic logic [43:0] isqrt88(input logic [87:0] n);
        logic [43:0] r;
        logic [43:0] t;
        logic [87:0] sq;
        r = 44'd0;
        for (int b = 43; b >= 0; b--) begin
            t  = r | (44'd1 << b);
            sq = {44'd0, t} * {44'd0, t};
            if (sq <= n) r = t;
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_done <= 1'b0;
            core_cnt  <= 3'd0;
            core_root <= 44'd0;
        end else begin
            core_done <= 1'b0;
            if (sqrt_start) begin
                core_cnt  <= 3'd4;
                core_root <= isqrt88({64'd0, sqrt_significand} << (sqrt_is_exp_odd ? 64 : 63));
            end else if (core_cnt != 3'd0) begin
                core_cnt <= core_cnt - 3'd1;
                if (core_cnt == 3'd1) core_done <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Launch one operation, wait for out_valid, record latencies, then accept the result.
    task automatic run_op(input logic [31:0] a, input logic [2:0] r,
                          output logic [31:0] res, output logic [4:0] fl,
                          output int lat, output int done_lat);
        int done_at;
        @(negedge clk);
        rs1   = a;
        rm    = r;
        start = 1'b1;
        lat     = 0;
        done_at = -1;
        while (1) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (sqrt_done) done_at = lat;
            if (out_valid || lat > 100) break;
        end
        if (!out_valid) check("timeout", {31'd0, out_valid}, 32'd1);
        res      = result;
        fl       = fflags;
        done_lat = (done_at < 0) ? -1 : lat - done_at;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic vec(input string tag, input logic [31:0] a, input logic [2:0] r,
                       input logic [31:0] exp_res, input logic [4:0] exp_fl, input bit special);
        logic [31:0] res;
        logic [4:0]  fl;
        int lat, dlat;
        run_op(a, r, res, fl, lat, dlat);
        check($sformatf("%s.res", tag), res, exp_res);
        check($sformatf("%s.flags", tag), {27'd0, fl}, {27'd0, exp_fl});
        if (special) check($sformatf("%s.lat_start", tag), 32'(lat), 32'd3);
        else         check($sformatf("%s.lat_done", tag), 32'(dlat), 32'd2);
        $display("op %s rs1=%h rm=%0d -> result=%h fflags=%h", tag, a, r, res, fl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset      = 1'b0;
        start      = 1'b0;
        rs1        = 32'd0;
        rm         = 3'd0;
        out_ready  = 1'b0;
        stray_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.fflags", {27'd0, fflags}, 32'd0);
        check("rst.sig", {8'd0, sqrt_significand}, 32'd0);
        check("rst.sqstart", {31'd0, sqrt_start}, 32'd0);
        reset = 1'b1;

        vec("sqrt4",   32'h4080_0000, 3'd0, 32'h4000_0000, 5'h00, 1'b0);
        check("sqrt4.sig", {8'd0, sqrt_significand}, 32'h0080_0000);
        check("sqrt4.odd", {31'd0, sqrt_is_exp_odd}, 32'd0);
        vec("sqrt2rne", 32'h4000_0000, 3'd0, 32'h3FB5_04F3, 5'h01, 1'b0);
        check("sqrt2.odd", {31'd0, sqrt_is_exp_odd}, 32'd1);
        vec("sqrt2rup", 32'h4000_0000, 3'd3, 32'h3FB5_04F4, 5'h01, 1'b0);
        vec("sqrt2rtz", 32'h4000_0000, 3'd1, 32'h3FB5_04F3, 5'h01, 1'b0);
        vec("sqrt2rdn", 32'h4000_0000, 3'd2, 32'h3FB5_04F3, 5'h01, 1'b0);
        vec("sqrt2rmm", 32'h4000_0000, 3'd4, 32'h3FB5_04F3, 5'h01, 1'b0);
        vec("nearfour_rne", 32'h407F_FFFF, 3'd0, 32'h3FFF_FFFF, 5'h01, 1'b0);
        vec("nearfour_rup", 32'h407F_FFFF, 3'd3, 32'h4000_0000, 5'h01, 1'b0);
        vec("one",     32'h3F80_0000, 3'd0, 32'h3F80_0000, 5'h00, 1'b0);
        vec("neg1",    32'hBF80_0000, 3'd0, 32'h7FC0_0000, 5'h10, 1'b1);
        vec("negzero", 32'h8000_0000, 3'd0, 32'h8000_0000, 5'h00, 1'b1);
        vec("posinf",  32'h7F80_0000, 3'd0, 32'h7F80_0000, 5'h00, 1'b1);
        vec("neginf",  32'hFF80_0000, 3'd0, 32'h7FC0_0000, 5'h10, 1'b1);
        vec("snan",    32'h7F80_0001, 3'd0, 32'h7FC0_0000, 5'h10, 1'b1);
        vec("qnan",    32'h7FC0_0000, 3'd0, 32'h7FC0_0000, 5'h00, 1'b1);
        vec("badrm",   32'h4080_0000, 3'd5, 32'h7FC0_0000, 5'h10, 1'b1);
`ifdef FSQRT_SUBNORM_EN
        vec("subnorm", 32'h0000_0001, 3'd0, 32'h1A35_04F3, 5'h01, 1'b0);
`else
        vec("subnorm", 32'h0000_0001, 3'd0, 32'h0000_0000, 5'h00, 1'b1);
`endif

        // Stray completion pulse while idle
        @(negedge clk);
        stray_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stray_done = 1'b0;
        check("stray.busy", {31'd0, busy}, 32'd0);
        check("stray.valid", {31'd0, out_valid}, 32'd0);

        // Back-pressure: hold result for 10 cycles, start attempts ignored
        rs1   = 32'h4080_0000;
        rm    = 3'd0;
        start = 1'b1;
        lat   = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (out_valid || lat > 100) break;
        end
        check("bp.first_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                start = 1'b1;
                rs1   = 32'h4110_0000;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            check($sformatf("bp.valid%0d", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp.res%0d", i), result, 32'h4000_0000);
        end
        $display("op backpressure held result=%h for 10 cycles", result);
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check("bp.idle_busy", {31'd0, busy}, 32'd0);
        check("bp.idle_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp.hs_start_ignored", {31'd0, busy}, 32'd0);

        // Reset while waiting on the core
        rs1   = 32'h4000_0000;
        rm    = 3'd0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstwait.busy_before", {31'd0, busy}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rstwait.busy", {31'd0, busy}, 32'd0);
        check("rstwait.valid", {31'd0, out_valid}, 32'd0);
        check("rstwait.sig", {8'd0, sqrt_significand}, 32'd0);
        $display("op reset-in-wait busy=%b out_valid=%b", busy, out_valid);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("rstwait.no_result", {31'd0, out_valid}, 32'd0);
        vec("sqrt9", 32'h4110_0000, 3'd0, 32'h4040_0000, 5'h00, 1'b0);
        check("sqrt9.sig", {8'd0, sqrt_significand}, 32'h0090_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
